serial_tx_scheduler: RTL
========================

Name: serial_tx_scheduler

Overview:
- Shares one Serial Transceiver instance between N_REQ requesters using round-robin arbitration.
- Per transaction: clears the transceiver, loads the granted requester's 32-bit word, starts the transfer, and strobes the shift-enable tick until done. It then acknowledges the requester.
- Sits between the calculator's result producers and the transceiver. Everything runs on one system clock; the shift rate comes from a clock-enable strobe, not a second clock.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DIV, 4, tx_tick period in clk cycles (>=2)
- TIMEOUT, 64, max clk cycles spent in WAIT before abort (>=DIV)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level
- req_data  in  32*N_REQ  requester i word in bits [32*i+31:32*i]
- gnt  out  N_REQ  one-hot grant, held for the whole transaction
- ack  out  N_REQ  one-cycle pulse to the granted requester on success
- err  out  N_REQ  one-cycle pulse to the granted requester on timeout
- busy  out  1  high whenever state != IDLE
- tx_din  out  32  word to transceiver
- tx_sample  out  1  transceiver load strobe
- tx_start  out  1  transceiver start strobe
- tx_clr  out  1  transceiver clear pulse (synchronous clear of transceiver state)
- tx_tick  out  1  shift-enable strobe
- tx_done  in  1  transceiver done flag (level)

Behaviour:
- Reset (reset=0, async) drives all outputs to 0 and state to IDLE. It also sets div_cnt=0, to_cnt=0 and rr_ptr=0 (requester 0 highest priority).
- States: IDLE, CLEAR, LOAD, START, WAIT, DONE, ABORT.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Latch its id and req_data word, then go to CLEAR.
  - If no req bit is set, stay in IDLE.
- gnt[id] goes high on the cycle CLEAR is entered. It stays high through DONE or ABORT and drops on return to IDLE.
- CLEAR: tx_clr=1 for exactly one cycle, then LOAD.
- LOAD: tx_sample=1 for one cycle, with tx_din = latched word. tx_din holds the latched word from LOAD until IDLE, and is 0 in IDLE. Next state is START.
- START: tx_start=1 for one cycle. tx_sample and tx_start are never both high. Next state is WAIT; div_cnt and to_cnt are cleared on entry.
- WAIT, per cycle:
  - div_cnt increments and wraps at DIV-1.
  - tx_tick=1 exactly on cycles where div_cnt==DIV-1. The first tick is on WAIT cycle DIV-1, counting the entry cycle as 0.
  - to_cnt increments.
- WAIT exits:
  - tx_done=1 sampled in WAIT goes to DONE, and no further ticks are issued.
  - Otherwise, to_cnt==TIMEOUT-1 goes to ABORT.
  - If both occur on the same cycle, tx_done wins.
- DONE: ack[id]=1 for one cycle, rr_ptr=(id+1) mod N_REQ, then IDLE.
- ABORT: err[id]=1 and tx_clr=1 for one cycle, rr_ptr=(id+1) mod N_REQ, then IDLE.
- Latency: req seen in IDLE at cycle 0 gives gnt at cycle 1, tx_sample at 2, tx_start at 3 and WAIT from cycle 4. ack comes one cycle after tx_done is sampled.
- Request handling:
  - req is sampled only in IDLE.
  - Deasserting req or changing req_data after the grant has no effect on the transaction in progress.
  - A new req arriving mid-transaction waits for IDLE.
- Fairness: a requester that holds req continuously is re-granted only after every other pending requester has been served once.
- Back-to-back: after DONE or ABORT the block spends exactly one IDLE cycle before the next CLEAR.
- Outputs are registered. tx_tick, tx_sample, tx_start, tx_clr, ack and err are single-cycle pulses. No output changes during reset.
- Reset asserted mid-transaction aborts immediately: all outputs go to 0 and no ack or err is issued.

Test Plan:
- Single request: req=4'b0001, req_data[31:0]=32'hDEADBEEF, transceiver model with LENGTH=4 (8 ticks to done).
  - Expect gnt=0001 at cycle 1, tx_sample with tx_din=DEADBEEF at cycle 2, tx_start at 3.
  - Expect ticks at cycles 7, 11, ... 35 (8 ticks), then ack[0] one cycle after tx_done.
- Round-robin: req=4'b1111 held.
  - Expect grant order 0, 1, 2, 3, 0, each with ack.
  - Expect exactly one IDLE cycle between transactions.
- Priority wrap: after serving id 2, req=4'b0101 → id 0 is granted next, not id 2.
- Timeout: tx_done held 0 → exactly 16 ticks (64/4), then err[id] and tx_clr pulsed together, gnt drops, busy=0 the following cycle.
- Simultaneous done and timeout: tx_done first seen on WAIT cycle 63 → ack, no err.
- Reset mid-WAIT: reset=0 at WAIT cycle 10 → all outputs 0 asynchronously. After release with req=0001, a clean transaction restarts from id 0 with the correct latency.

Source files
------------

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one serial transceiver between N_REQ requesters.
// Each grant runs clear -> load -> start -> tick until done (ack) or timeout (err).
module serial_tx_scheduler #(
   parameter int N_REQ   = 4,
   parameter int DIV     = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req,
   input  logic [32*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     ack,
   output logic [N_REQ-1:0]     err,
   output logic                 busy,
   output logic [31:0]          tx_din,
   output logic                 tx_sample,
   output logic                 tx_start,
   output logic                 tx_clr,
   output logic                 tx_tick,
   input  logic                 tx_done
);

   localparam int IW = $clog2(N_REQ);
   localparam int DW = $clog2(DIV);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT, S_DONE, S_ABORT
   } state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   id, rr_ptr, pick_id, cur_id;
   logic            pick_valid;
   logic [31:0]     word;
   logic [DW-1:0]   div_cnt, div_nxt;
   logic [TW-1:0]   to_cnt, to_nxt;
   logic [N_REQ-1:0] cur_oh;

   // First set request at or above rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         int idx;
         idx = (int'(rr_ptr) + i) % N_REQ;
         if (!pick_valid && req[idx]) begin
            pick_valid = 1'b1;
            pick_id    = IW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      to_nxt    = to_cnt;
      case (state)
         S_IDLE:  if (pick_valid) state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_START;
         S_START: begin
            state_nxt = S_WAIT;
            div_nxt   = '0;
            to_nxt    = '0;
         end
         S_WAIT: begin
            div_nxt = (div_cnt == DW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
            to_nxt  = to_cnt + 1'b1;
            // Done has priority over a coincident timeout.
            if (tx_done)                            state_nxt = S_DONE;
            else if (to_cnt == TW'(TIMEOUT - 1))    state_nxt = S_ABORT;
         end
         S_DONE, S_ABORT: state_nxt = S_IDLE;
         default:         state_nxt = S_IDLE;
      endcase
   end

   // On the IDLE->CLEAR edge the id is not latched yet, so use the arbiter pick.
   assign cur_id = (state == S_IDLE) ? pick_id : id;
   assign cur_oh = N_REQ'(1) << cur_id;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         id        <= '0;
         rr_ptr    <= '0;
         word      <= '0;
         div_cnt   <= '0;
         to_cnt    <= '0;
         gnt       <= '0;
         ack       <= '0;
         err       <= '0;
         busy      <= 1'b0;
         tx_din    <= '0;
         tx_sample <= 1'b0;
         tx_start  <= 1'b0;
         tx_clr    <= 1'b0;
         tx_tick   <= 1'b0;
      end else begin
         state   <= state_nxt;
         div_cnt <= div_nxt;
         to_cnt  <= to_nxt;
         if (state == S_IDLE && pick_valid) begin
            id   <= pick_id;
            word <= req_data[32*pick_id +: 32];
         end
         if (state == S_DONE || state == S_ABORT)
            rr_ptr <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;

         // Outputs are registered from the next state so they align with it.
         gnt       <= (state_nxt != S_IDLE) ? cur_oh : '0;
         ack       <= (state_nxt == S_DONE) ? cur_oh : '0;
         err       <= (state_nxt == S_ABORT) ? cur_oh : '0;
         busy      <= (state_nxt != S_IDLE);
         tx_din    <= (state_nxt inside {S_LOAD, S_START, S_WAIT, S_DONE, S_ABORT}) ? word : '0;
         tx_sample <= (state_nxt == S_LOAD);
         tx_start  <= (state_nxt == S_START);
         tx_clr    <= (state_nxt == S_CLEAR) || (state_nxt == S_ABORT);
         tx_tick   <= (state_nxt == S_WAIT) && (div_nxt == DW'(DIV - 1));
      end
   end

endmodule
